// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, one outstanding imem read at a time,
// and a small in-order instruction FIFO that a redirect flushes.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [63:0] o_inst_pc,
  output logic        o_inst_fault,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  state_e            state_q;
  logic [63:0]       pc_q, req_pc_q, addr_q;
  logic              req_q, drop_q;
  entry_t [DEPTH-1:0] fifo_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic              push, pop;
  logic [63:0]       nxt_pc_d, redir_pc_d;

  assign pop        = (cnt_q != '0) && i_inst_ready;
  assign push       = (state_q == WAIT) && i_imem_rvalid && !drop_q;
  assign cnt_d      = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  // A dropped response must not advance the PC that a redirect installed.
  assign nxt_pc_d   = drop_q ? pc_q : req_pc_q + 64'd4;
  assign redir_pc_d = i_redirect_pc & ~64'd3;

  assign o_imem_req   = req_q;
  assign o_imem_addr  = addr_q;
  assign o_inst_valid = (cnt_q != '0);
  assign o_inst       = fifo_q[rd_ptr_q].inst;
  assign o_inst_pc    = fifo_q[rd_ptr_q].pc;
  assign o_inst_fault = fifo_q[rd_ptr_q].fault;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (i_redirect) begin
      pc_q     <= redir_pc_d;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      case (state_q)
        // A grant we cannot cancel leaves a response in flight; wait and discard it.
        REQ: begin
          if (i_imem_gnt) begin
            state_q <= WAIT;
            drop_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: i_imem_rdata, fault: i_imem_err};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (cnt_q < DEPTH_C) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (i_imem_gnt) begin
            state_q  <= WAIT;
            req_q    <= 1'b0;
            req_pc_q <= addr_q;
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            drop_q <= 1'b0;
            pc_q   <= nxt_pc_d;
            if (cnt_d < DEPTH_C) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= nxt_pc_d;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
